// File: rtl/policy_generator_if.sv
// Q-value / action bundle between the Q-table banks, the policy stage and its consumer.
// Latency: none, this is only a bundle of wires.
// Backpressure: none; every a_valid pulse must be accepted downstream.
// Ports: q_valid, q0..q3 (signed Q(s,a)), mode_learn, epsilon in;
//        a_valid, A, q_max, a_explore out of the policy stage.
interface policy_generator_if #(
  parameter int DW = 32
);
  logic                 q_valid;
  logic signed [DW-1:0] q0;
  logic signed [DW-1:0] q1;
  logic signed [DW-1:0] q2;
  logic signed [DW-1:0] q3;
  logic                 mode_learn;
  logic [15:0]          epsilon;
  logic                 a_valid;
  logic [1:0]           A;
  logic signed [DW-1:0] q_max;
  logic                 a_explore;

  // master drives Q-values and controls; slave is the policy stage
  modport master (
    output q_valid, q0, q1, q2, q3, mode_learn, epsilon,
    input  a_valid, A, q_max, a_explore
  );

  modport slave (
    input  q_valid, q0, q1, q2, q3, mode_learn, epsilon,
    output a_valid, A, q_max, a_explore
  );
endinterface

// File: rtl/policy_generator.sv
// Epsilon-greedy action selection over four signed Q-values with greedy max export.
// Latency: 3 cycles from q_valid to a_valid, one sample per cycle.
// Backpressure: none; bubbles pass through one-for-one.
// Ports: clk, rst (sync active-low), bus (slave side of policy_generator_if).
module policy_generator #(
  parameter int          DW        = 32,
  parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
  input  logic          clk,
  input  logic          rst,
  policy_generator_if.slave bus
);

  // An all-zero seed would lock the LFSR at zero forever
  localparam logic [15:0] SEED = (LFSR_SEED == 16'h0000) ? 16'h0001 : LFSR_SEED;

  logic [15:0] r;

  // Stage 1: pairwise maxima plus sampled controls
  logic                 v1;
  logic signed [DW-1:0] m01;
  logic signed [DW-1:0] m23;
  logic                 i01;
  logic                 i23;
  logic [15:0]          rs1;
  logic                 learn1;
  logic [15:0]          eps1;

  // Stage 2: overall maximum and its index
  logic                 v2;
  logic signed [DW-1:0] m2;
  logic [1:0]           idx2;
  logic [15:0]          rs2;
  logic                 learn2;
  logic [15:0]          eps2;

  logic                 explore;
  logic                 hi_wins;

  // rs is never zero, so eps == 0 can never explore
  assign explore = learn2 && (rs2 < eps2);
  // strict compare: ties keep the lower-index pair
  assign hi_wins = (m23 > m01);

  always_ff @(posedge clk) begin
    if (!rst) begin
      r             <= SEED;
      v1            <= 1'b0;
      m01           <= '0;
      m23           <= '0;
      i01           <= 1'b0;
      i23           <= 1'b0;
      rs1           <= '0;
      learn1        <= 1'b0;
      eps1          <= '0;
      v2            <= 1'b0;
      m2            <= '0;
      idx2          <= '0;
      rs2           <= '0;
      learn2        <= 1'b0;
      eps2          <= '0;
      bus.a_valid   <= 1'b0;
      bus.A         <= 2'd0;
      bus.q_max     <= '0;
      bus.a_explore <= 1'b0;
    end else begin
      // Galois right-shift LFSR, free-running
      r <= {1'b0, r[15:1]} ^ (r[0] ? 16'hB400 : 16'h0000);

      v1 <= bus.q_valid;
      if (bus.q_valid) begin
        // strict compares so ties resolve to the lower action
        m01    <= (bus.q1 > bus.q0) ? bus.q1 : bus.q0;
        i01    <= (bus.q1 > bus.q0);
        m23    <= (bus.q3 > bus.q2) ? bus.q3 : bus.q2;
        i23    <= (bus.q3 > bus.q2);
        rs1    <= r;
        learn1 <= bus.mode_learn;
        eps1   <= bus.epsilon;
      end

      v2 <= v1;
      if (v1) begin
        m2     <= hi_wins ? m23 : m01;
        idx2   <= hi_wins ? {1'b1, i23} : {1'b0, i01};
        rs2    <= rs1;
        learn2 <= learn1;
        eps2   <= eps1;
      end

      bus.a_valid <= v2;
      if (v2) begin
        bus.A         <= explore ? rs2[1:0] : idx2;
        bus.q_max     <= m2;
        bus.a_explore <= explore;
      end
    end
  end

endmodule
